// File: rtl/csr_sync_readback.sv
// Device-to-host readback for the core synchronize handshake: snapshots status
// words under a sequence tag, waits for the host ack, and publishes counters.
module csr_sync_readback #(
   parameter int unsigned NUM_STATUS = 4,
   parameter int unsigned CNT_WIDTH  = 48
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          synchronize,
   input  logic [64*NUM_STATUS-1:0]      status_in,
   input  logic                          ack_wr_en,
   input  logic [63:0]                   ack_wr_data,
   output logic                          synchronize_done,
   output logic [64*(3+NUM_STATUS)-1:0]  rd_csr_data
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      DONE     = 2'd2
   } state_t;

   state_t               state, state_nx;
   logic [31:0]          seq, seq_nx;
   logic                 pending, pending_nx;
   logic                 overflow, overflow_nx;
   logic [15:0]          stale_cnt, stale_nx, stale_sat;
   logic [CNT_WIDTH-1:0] cycle_cnt;
   logic [CNT_WIDTH-1:0] lat_cnt, lat_nx, lat_inc;
   logic [CNT_WIDTH-1:0] latency, latency_nx;
   logic [63:0]          snap    [NUM_STATUS];
   logic [63:0]          snap_nx [NUM_STATUS];
   logic                 ack_match;
   logic                 unused_ack_hi;

   // Only the low half of the ack word carries the sequence number.
   assign unused_ack_hi = ^ack_wr_data[63:32];
   assign ack_match     = ack_wr_en && (ack_wr_data[31:0] == seq);
   assign lat_inc       = (lat_cnt == '1) ? lat_cnt : lat_cnt + 1'b1;
   assign stale_sat     = (stale_cnt == '1) ? stale_cnt : stale_cnt + 16'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         seq       <= '0;
         pending   <= 1'b0;
         overflow  <= 1'b0;
         stale_cnt <= '0;
         cycle_cnt <= '0;
         lat_cnt   <= '0;
         latency   <= '0;
         for (int unsigned i = 0; i < NUM_STATUS; i++) begin
            snap[i] <= '0;
         end
      end else begin
         state     <= state_nx;
         seq       <= seq_nx;
         pending   <= pending_nx;
         overflow  <= overflow_nx;
         stale_cnt <= stale_nx;
         cycle_cnt <= cycle_cnt + 1'b1;
         lat_cnt   <= lat_nx;
         latency   <= latency_nx;
         for (int unsigned i = 0; i < NUM_STATUS; i++) begin
            snap[i] <= snap_nx[i];
         end
      end
   end

   always_comb begin
      state_nx    = state;
      seq_nx      = seq;
      pending_nx  = pending;
      overflow_nx = overflow;
      stale_nx    = stale_cnt;
      lat_nx      = lat_cnt;
      latency_nx  = latency;
      for (int unsigned i = 0; i < NUM_STATUS; i++) begin
         snap_nx[i] = snap[i];
      end

      case (state)
         IDLE: begin
            if (synchronize || pending) begin
               state_nx   = WAIT_ACK;
               seq_nx     = seq + 32'd1;
               pending_nx = 1'b0;
               lat_nx     = '0;
               for (int unsigned i = 0; i < NUM_STATUS; i++) begin
                  snap_nx[i] = status_in[64*i +: 64];
               end
            end
            if (ack_wr_en) begin
               stale_nx = stale_sat;
            end
         end
         WAIT_ACK: begin
            lat_nx = lat_inc;
            if (synchronize) begin
               if (pending) begin
                  overflow_nx = 1'b1;
               end else begin
                  pending_nx = 1'b1;
               end
            end
            // Latency reported includes the ack cycle itself.
            if (ack_match) begin
               latency_nx = lat_inc;
               state_nx   = DONE;
            end else if (ack_wr_en) begin
               stale_nx = stale_sat;
            end
         end
         DONE: begin
            state_nx = IDLE;
            if (synchronize) begin
               if (pending) begin
                  overflow_nx = 1'b1;
               end else begin
                  pending_nx = 1'b1;
               end
            end
            if (ack_wr_en) begin
               stale_nx = stale_sat;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // DONE lasts exactly one cycle, so the state register itself is the pulse.
   assign synchronize_done = (state == DONE);

   always_comb begin
      rd_csr_data        = '0;
      rd_csr_data[63:0]  = {seq, stale_cnt, 13'b0, overflow, pending, (state == WAIT_ACK)};
      rd_csr_data[127:64] = 64'(cycle_cnt);
      rd_csr_data[191:128] = 64'(latency);
      for (int unsigned i = 0; i < NUM_STATUS; i++) begin
         rd_csr_data[64*(3+i) +: 64] = snap[i];
      end
   end

endmodule

// File: tb/tb_csr_sync_readback.sv
// Scoreboard bench for csr_sync_readback: publishes and acks are queued as they
// are driven and popped when the readback words should reflect them.
module tb_csr_sync_readback;

   localparam int unsigned NS = 4;
   localparam int unsigned CW = 48;
   localparam int unsigned NW = 3 + NS;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 synchronize;
   logic [64*NS-1:0]     status_in;
   logic                 ack_wr_en;
   logic [63:0]          ack_wr_data;
   logic                 synchronize_done;
   logic [64*NW-1:0]     rd_csr_data;

   typedef struct packed {
      logic [31:0]      seq;
      logic [64*NS-1:0] snap;
   } pub_t;

   pub_t           exp_pub[$];
   logic [CW-1:0]  exp_lat[$];
   logic [31:0]    exp_seq;
   logic [15:0]    exp_stale;
   logic           exp_ovf;
   logic [CW-1:0]  exp_cyc;
   int unsigned    vectors = 0;
   int unsigned    miscompares = 0;

   csr_sync_readback #(
      .NUM_STATUS(NS),
      .CNT_WIDTH (CW)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .synchronize     (synchronize),
      .status_in       (status_in),
      .ack_wr_en       (ack_wr_en),
      .ack_wr_data     (ack_wr_data),
      .synchronize_done(synchronize_done),
      .rd_csr_data     (rd_csr_data)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] word(input int unsigned k);
      return rd_csr_data[64*k +: 64];
   endfunction

   function automatic logic [63:0] exp_w0(input logic busy, input logic pend);
      return {exp_seq, exp_stale, 13'b0, exp_ovf, pend, busy};
   endfunction

   function automatic logic [64*NS-1:0] rand_status();
      logic [64*NS-1:0] s;
      for (int i = 0; i < int'(NS); i++) begin
         s[64*i +: 64] = {$urandom, $urandom};
      end
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      if (reset) exp_cyc = '0;
      else       exp_cyc = exp_cyc + 1'b1;
      #1;
   endtask

   task automatic start_publish(input logic [64*NS-1:0] st);
      pub_t p;
      status_in   = st;
      synchronize = 1'b1;
      p.seq  = exp_seq + 32'd1;
      p.snap = st;
      exp_pub.push_back(p);
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      synchronize = 1'b0;
      ack_wr_en   = 1'b0;
      ack_wr_data = '0;
      status_in   = rand_status();
      exp_seq     = '0;
      exp_stale   = '0;
      exp_ovf     = 1'b0;
      exp_cyc     = '0;
      tick();
      tick();
      vectors++;
      if (rd_csr_data !== '0) begin
         miscompares++;
         $display("FAIL reset_words: got %h expected 0", rd_csr_data);
      end
      vectors++;
      if (synchronize_done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_done: got %b expected 0", synchronize_done);
      end
      reset = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         vectors++;
         if (word(1) !== 64'(exp_cyc) || exp_cyc !== CW'(i)) begin
            miscompares++;
            $display("FAIL idle_cycle_cnt: got %0d expected %0d", word(1), i);
         end
         vectors++;
         if (word(0) !== 64'h0) begin
            miscompares++;
            $display("FAIL idle_word0: got %h expected 0", word(0));
         end
         vectors++;
         if (synchronize_done !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_done: got %b expected 0", synchronize_done);
         end
      end
   endtask

   task automatic test_publish_ack();
      logic [64*NS-1:0] st;
      pub_t             p;
      logic [CW-1:0]    lat;
      st = rand_status();
      st[63:0] = 64'hDEAD_BEEF_0000_0001;
      start_publish(st);
      tick();
      synchronize = 1'b0;
      status_in   = ~st;
      exp_seq     = exp_seq + 32'd1;
      p = exp_pub.pop_front();
      vectors++;
      if (word(3) !== 64'hDEAD_BEEF_0000_0001 || rd_csr_data[64*3 +: 64*NS] !== p.snap) begin
         miscompares++;
         $display("FAIL publish_snapshot: got %h expected %h", rd_csr_data[64*3 +: 64*NS], p.snap);
      end
      vectors++;
      if (word(0) !== exp_w0(1'b1, 1'b0) || rd_csr_data[63:32] !== p.seq) begin
         miscompares++;
         $display("FAIL publish_word0: got %h expected %h", word(0), exp_w0(1'b1, 1'b0));
      end
      vectors++;
      if (word(1) !== 64'(exp_cyc)) begin
         miscompares++;
         $display("FAIL publish_cycle_cnt: got %0d expected %0d", word(1), exp_cyc);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (synchronize_done !== 1'b0) begin
            miscompares++;
            $display("FAIL early_done: got %b expected 0 at wait cycle %0d", synchronize_done, i);
         end
      end
      ack_wr_en   = 1'b1;
      ack_wr_data = {32'h0, exp_seq};
      exp_lat.push_back(CW'(5));
      tick();
      ack_wr_en = 1'b0;
      lat = exp_lat.pop_front();
      vectors++;
      if (synchronize_done !== 1'b1) begin
         miscompares++;
         $display("FAIL ack_done: got %b expected 1", synchronize_done);
      end
      vectors++;
      if (word(2) !== 64'(lat)) begin
         miscompares++;
         $display("FAIL ack_latency: got %0d expected %0d", word(2), lat);
      end
      vectors++;
      if (word(0) !== exp_w0(1'b0, 1'b0) || word(3) !== 64'hDEAD_BEEF_0000_0001) begin
         miscompares++;
         $display("FAIL ack_hold: got w0=%h w3=%h expected w0=%h w3=deadbeef00000001",
                  word(0), word(3), exp_w0(1'b0, 1'b0));
      end
      tick();
      vectors++;
      if (synchronize_done !== 1'b0) begin
         miscompares++;
         $display("FAIL done_width: got %b expected 0", synchronize_done);
      end
   endtask

   task automatic test_stale_ack();
      pub_t          p;
      logic [CW-1:0] lat;
      start_publish(rand_status());
      tick();
      synchronize = 1'b0;
      exp_seq     = exp_seq + 32'd1;
      p = exp_pub.pop_front();
      vectors++;
      if (rd_csr_data[63:32] !== p.seq || rd_csr_data[64*3 +: 64*NS] !== p.snap) begin
         miscompares++;
         $display("FAIL stale_publish: got seq %h expected %h", rd_csr_data[63:32], p.seq);
      end
      ack_wr_en   = 1'b1;
      ack_wr_data = {32'h0, exp_seq + 32'd5};
      tick();
      exp_stale = exp_stale + 16'd1;
      vectors++;
      if (synchronize_done !== 1'b0 || word(0) !== exp_w0(1'b1, 1'b0)) begin
         miscompares++;
         $display("FAIL stale_mismatch: got done=%b w0=%h expected done=0 w0=%h",
                  synchronize_done, word(0), exp_w0(1'b1, 1'b0));
      end
      ack_wr_data = {32'hFFFF_FFFF, exp_seq};
      exp_lat.push_back(CW'(2));
      tick();
      lat = exp_lat.pop_front();
      vectors++;
      if (synchronize_done !== 1'b1 || word(2) !== 64'(lat)) begin
         miscompares++;
         $display("FAIL stale_match: got done=%b lat=%0d expected done=1 lat=%0d",
                  synchronize_done, word(2), lat);
      end
      vectors++;
      if (word(0) !== exp_w0(1'b0, 1'b0)) begin
         miscompares++;
         $display("FAIL stale_keep: got %h expected %h", word(0), exp_w0(1'b0, 1'b0));
      end
      tick();
      exp_stale = exp_stale + 16'd1;
      vectors++;
      if (synchronize_done !== 1'b0 || word(0) !== exp_w0(1'b0, 1'b0) || word(2) !== 64'(lat)) begin
         miscompares++;
         $display("FAIL ack_in_done: got done=%b w0=%h w2=%0d expected done=0 w0=%h w2=%0d",
                  synchronize_done, word(0), word(2), exp_w0(1'b0, 1'b0), lat);
      end
      tick();
      ack_wr_en = 1'b0;
      exp_stale = exp_stale + 16'd1;
      vectors++;
      if (synchronize_done !== 1'b0 || word(0) !== exp_w0(1'b0, 1'b0)) begin
         miscompares++;
         $display("FAIL ack_in_idle: got done=%b w0=%h expected done=0 w0=%h",
                  synchronize_done, word(0), exp_w0(1'b0, 1'b0));
      end
   endtask

   task automatic test_back_to_back();
      logic [64*NS-1:0] st_a, st_c, st_d;
      pub_t             p, q;
      logic [CW-1:0]    lat;
      st_a = rand_status();
      st_c = rand_status();
      st_d = rand_status();
      start_publish(st_a);
      tick();
      synchronize = 1'b0;
      exp_seq     = exp_seq + 32'd1;
      p = exp_pub.pop_front();
      vectors++;
      if (rd_csr_data[63:32] !== p.seq || rd_csr_data[64*3 +: 64*NS] !== p.snap) begin
         miscompares++;
         $display("FAIL b2b_first: got seq %h expected %h", rd_csr_data[63:32], p.seq);
      end
      status_in   = st_c;
      synchronize = 1'b1;
      q.seq  = exp_seq + 32'd1;
      q.snap = st_c;
      exp_pub.push_back(q);
      tick();
      vectors++;
      if (word(0) !== exp_w0(1'b1, 1'b1)) begin
         miscompares++;
         $display("FAIL b2b_pending: got %h expected %h", word(0), exp_w0(1'b1, 1'b1));
      end
      tick();
      synchronize = 1'b0;
      exp_ovf     = 1'b1;
      vectors++;
      if (word(0) !== exp_w0(1'b1, 1'b1)) begin
         miscompares++;
         $display("FAIL b2b_overflow: got %h expected %h", word(0), exp_w0(1'b1, 1'b1));
      end
      tick();
      ack_wr_en   = 1'b1;
      ack_wr_data = {32'h0, exp_seq};
      exp_lat.push_back(CW'(4));
      tick();
      ack_wr_en = 1'b0;
      lat = exp_lat.pop_front();
      vectors++;
      if (synchronize_done !== 1'b1 || word(2) !== 64'(lat) || word(0) !== exp_w0(1'b0, 1'b1)) begin
         miscompares++;
         $display("FAIL b2b_ack: got done=%b lat=%0d w0=%h expected done=1 lat=%0d w0=%h",
                  synchronize_done, word(2), word(0), lat, exp_w0(1'b0, 1'b1));
      end
      tick();
      vectors++;
      if (synchronize_done !== 1'b0 || rd_csr_data[64*3 +: 64*NS] !== st_a
          || word(0) !== exp_w0(1'b0, 1'b1)) begin
         miscompares++;
         $display("FAIL b2b_gap: got done=%b w0=%h expected done=0 w0=%h, snapshot held",
                  synchronize_done, word(0), exp_w0(1'b0, 1'b1));
      end
      tick();
      exp_seq = exp_seq + 32'd1;
      p = exp_pub.pop_front();
      vectors++;
      if (rd_csr_data[63:32] !== p.seq || rd_csr_data[64*3 +: 64*NS] !== p.snap
          || word(0) !== exp_w0(1'b1, 1'b0)) begin
         miscompares++;
         $display("FAIL b2b_second: got w0=%h snap=%h expected w0=%h snap=%h",
                  word(0), rd_csr_data[64*3 +: 64*NS], exp_w0(1'b1, 1'b0), p.snap);
      end
      status_in   = st_d;
      synchronize = 1'b1;
      ack_wr_en   = 1'b1;
      ack_wr_data = {32'h0, exp_seq};
      q.seq  = exp_seq + 32'd1;
      q.snap = st_d;
      exp_pub.push_back(q);
      exp_lat.push_back(CW'(1));
      tick();
      synchronize = 1'b0;
      ack_wr_en   = 1'b0;
      lat = exp_lat.pop_front();
      vectors++;
      if (synchronize_done !== 1'b1 || word(2) !== 64'(lat) || word(0) !== exp_w0(1'b0, 1'b1)) begin
         miscompares++;
         $display("FAIL sync_with_ack: got done=%b lat=%0d w0=%h expected done=1 lat=%0d w0=%h",
                  synchronize_done, word(2), word(0), lat, exp_w0(1'b0, 1'b1));
      end
      tick();
      tick();
      exp_seq = exp_seq + 32'd1;
      p = exp_pub.pop_front();
      vectors++;
      if (rd_csr_data[63:32] !== p.seq || rd_csr_data[64*3 +: 64*NS] !== p.snap
          || word(0) !== exp_w0(1'b1, 1'b0)) begin
         miscompares++;
         $display("FAIL sync_with_ack_publish: got w0=%h expected %h", word(0), exp_w0(1'b1, 1'b0));
      end
      ack_wr_en   = 1'b1;
      ack_wr_data = {32'h0, exp_seq};
      tick();
      ack_wr_en = 1'b0;
      vectors++;
      if (synchronize_done !== 1'b1 || word(2) !== 64'd1) begin
         miscompares++;
         $display("FAIL b2b_final_ack: got done=%b lat=%0d expected done=1 lat=1",
                  synchronize_done, word(2));
      end
      tick();
   endtask

   task automatic test_seq_wrap();
      pub_t p;
      force dut.seq = 32'hFFFF_FFFF;
      tick();
      release dut.seq;
      exp_seq = 32'hFFFF_FFFF;
      tick();
      vectors++;
      if (word(0) !== exp_w0(1'b0, 1'b0)) begin
         miscompares++;
         $display("FAIL wrap_preload: got %h expected %h", word(0), exp_w0(1'b0, 1'b0));
      end
      start_publish(rand_status());
      tick();
      synchronize = 1'b0;
      exp_seq     = exp_seq + 32'd1;
      p = exp_pub.pop_front();
      vectors++;
      if (rd_csr_data[63:32] !== 32'h0 || p.seq !== rd_csr_data[63:32]
          || rd_csr_data[64*3 +: 64*NS] !== p.snap) begin
         miscompares++;
         $display("FAIL wrap_seq: got %h expected 00000000", rd_csr_data[63:32]);
      end
      ack_wr_en   = 1'b1;
      ack_wr_data = 64'h0;
      tick();
      ack_wr_en = 1'b0;
      vectors++;
      if (synchronize_done !== 1'b1 || word(2) !== 64'd1 || word(0) !== exp_w0(1'b0, 1'b0)) begin
         miscompares++;
         $display("FAIL wrap_ack: got done=%b w0=%h expected done=1 w0=%h",
                  synchronize_done, word(0), exp_w0(1'b0, 1'b0));
      end
      tick();
   endtask

   task automatic test_reset_mid();
      pub_t p;
      start_publish(rand_status());
      tick();
      synchronize = 1'b0;
      exp_seq     = exp_seq + 32'd1;
      p = exp_pub.pop_front();
      vectors++;
      if (rd_csr_data[63:32] !== p.seq || word(0) !== exp_w0(1'b1, 1'b0)) begin
         miscompares++;
         $display("FAIL mid_publish: got %h expected %h", word(0), exp_w0(1'b1, 1'b0));
      end
      tick();
      reset       = 1'b1;
      ack_wr_en   = 1'b1;
      ack_wr_data = {32'h0, exp_seq};
      tick();
      reset     = 1'b0;
      ack_wr_en = 1'b0;
      exp_seq   = '0;
      exp_stale = '0;
      exp_ovf   = 1'b0;
      vectors++;
      if (synchronize_done !== 1'b0 || rd_csr_data !== '0) begin
         miscompares++;
         $display("FAIL mid_reset: got done=%b words=%h expected done=0 words=0",
                  synchronize_done, rd_csr_data);
      end
      tick();
      vectors++;
      if (synchronize_done !== 1'b0 || word(0) !== 64'h0 || word(1) !== 64'(exp_cyc)) begin
         miscompares++;
         $display("FAIL post_reset: got done=%b w0=%h w1=%0d expected done=0 w0=0 w1=%0d",
                  synchronize_done, word(0), word(1), exp_cyc);
      end
      start_publish(rand_status());
      tick();
      synchronize = 1'b0;
      exp_seq     = exp_seq + 32'd1;
      p = exp_pub.pop_front();
      vectors++;
      if (rd_csr_data[63:32] !== 32'd1 || p.seq !== 32'd1 || rd_csr_data[64*3 +: 64*NS] !== p.snap) begin
         miscompares++;
         $display("FAIL post_reset_seq: got %h expected 00000001", rd_csr_data[63:32]);
      end
      ack_wr_en   = 1'b1;
      ack_wr_data = {32'h0, exp_seq};
      tick();
      ack_wr_en = 1'b0;
      vectors++;
      if (synchronize_done !== 1'b1) begin
         miscompares++;
         $display("FAIL post_reset_ack: got %b expected 1", synchronize_done);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_publish_ack();
      test_stale_ack();
      test_back_to_back();
      test_seq_wrap();
      test_reset_mid();
      vectors++;
      if (exp_pub.size() != 0 || exp_lat.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d/%0d entries left expected 0/0",
                  exp_pub.size(), exp_lat.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
